// File: rtl/eyeriss_pkg.sv
// Shared defaults and state encoding for the PE sequencing controller.
package eyeriss_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_PSUM_W = 32;
  localparam int DEF_S_MAX  = 8;
  localparam int DEF_W_MAX  = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    COMPUTE,
    OUT
  } pe_seq_state_t;

endpackage

// File: rtl/spad_rf.sv
// Scratchpad register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; every entry is written before it is read.
module spad_rf #(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pe_seq_ctrl.sv
// Sequencer driving one external single-cycle MAC PE through a 1-D convolution.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; config checked here, err on bad config
// LOAD_W   | accepting S weights into wbuf
// LOAD_I   | accepting W activations into ibuf
// COMPUTE  | one MAC per cycle, k = 0..S-1, for output o
// OUT      | PE recirculates its sum; result offered on the o stream
module pe_seq_ctrl
  import eyeriss_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int S_MAX  = DEF_S_MAX,
  parameter int W_MAX  = DEF_W_MAX
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [$clog2(S_MAX+1)-1:0] cfg_s,
  input  logic [$clog2(W_MAX+1)-1:0] cfg_w,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_W-1:0]          w_data,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [DATA_W-1:0]          i_data,
  output logic [DATA_W-1:0]          pe_image_val,
  output logic                       pe_image_en,
  output logic [DATA_W-1:0]          pe_weight_val,
  output logic                       pe_weight_en,
  output logic [PSUM_W-1:0]          pe_psum_in,
  input  logic [PSUM_W-1:0]          pe_psum_out,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [PSUM_W-1:0]          o_data
);

  // Counters share the image-length width; S_MAX never exceeds W_MAX.
  localparam int CW  = $clog2(W_MAX+1);
  localparam int SAW = (S_MAX > 1) ? $clog2(S_MAX) : 1;
  localparam int IAW = (W_MAX > 1) ? $clog2(W_MAX) : 1;

  pe_seq_state_t state_q, state_d;
  logic [CW-1:0] k_q, k_d, o_q, o_d, s_q, s_d, w_q, w_d;
  logic          done_q, done_d, err_q, err_d;
  logic          wbuf_we, ibuf_we;
  logic [DATA_W-1:0] wbuf_rdata, ibuf_rdata;
  logic [IAW-1:0]    ipos;
  logic [CW-1:0]     cfg_s_ext;
  logic              cfg_ok, k_last_s, k_last_w, o_last;

  assign cfg_s_ext = CW'(cfg_s);
  assign cfg_ok    = (cfg_s_ext != '0) && (cfg_s_ext <= CW'(S_MAX)) &&
                     (cfg_w >= cfg_s_ext) && (cfg_w <= CW'(W_MAX));
  assign k_last_s  = (k_q == s_q - CW'(1));
  assign k_last_w  = (k_q == w_q - CW'(1));
  assign o_last    = (o_q == w_q - s_q);
  assign ipos      = o_q[IAW-1:0] + k_q[IAW-1:0];

  spad_rf #(.DEPTH(S_MAX), .WIDTH(DATA_W), .ADDR_W(SAW)) u_wbuf (
    .clk   (clk),
    .we    (wbuf_we),
    .waddr (k_q[SAW-1:0]),
    .wdata (w_data),
    .raddr (k_q[SAW-1:0]),
    .rdata (wbuf_rdata)
  );

  spad_rf #(.DEPTH(W_MAX), .WIDTH(DATA_W), .ADDR_W(IAW)) u_ibuf (
    .clk   (clk),
    .we    (ibuf_we),
    .waddr (k_q[IAW-1:0]),
    .wdata (i_data),
    .raddr (ipos),
    .rdata (ibuf_rdata)
  );

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;

  // state, counters, latched config and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      o_q     <= '0;
      s_q     <= '0;
      w_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      o_q     <= o_d;
      s_q     <= s_d;
      w_q     <= w_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // next-state, stream handshakes and PE drive
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    o_d           = o_q;
    s_d           = s_q;
    w_d           = w_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    w_ready       = 1'b0;
    i_ready       = 1'b0;
    wbuf_we       = 1'b0;
    ibuf_we       = 1'b0;
    pe_image_en   = 1'b0;
    pe_weight_en  = 1'b0;
    pe_image_val  = '0;
    pe_weight_val = '0;
    pe_psum_in    = '0;
    o_valid       = 1'b0;
    o_data        = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            s_d     = cfg_s_ext;
            w_d     = cfg_w;
            k_d     = '0;
            o_d     = '0;
            state_d = LOAD_W;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid) begin
          wbuf_we = 1'b1;
          if (k_last_s) begin
            k_d     = '0;
            state_d = LOAD_I;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      LOAD_I: begin
        i_ready = 1'b1;
        if (i_valid) begin
          ibuf_we = 1'b1;
          if (k_last_w) begin
            k_d     = '0;
            o_d     = '0;
            state_d = COMPUTE;
          end else begin
            k_d = k_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        pe_image_en   = 1'b1;
        pe_weight_en  = 1'b1;
        pe_image_val  = ibuf_rdata;
        pe_weight_val = wbuf_rdata;
        pe_psum_in    = (k_q == '0) ? '0 : pe_psum_out;
        k_d           = k_q + CW'(1);
        if (k_last_s) state_d = OUT;
      end
      OUT: begin
        // The PE keeps re-registering its own sum, so o_data holds under stall.
        pe_psum_in = pe_psum_out;
        o_valid    = 1'b1;
        o_data     = pe_psum_out;
        if (o_ready) begin
          if (o_last) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            o_d     = o_q + CW'(1);
            k_d     = '0;
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
